// File: rtl/wb_master_standard.sv
// Wishbone classic standard-cycle initiator: single/incrementing block transfers
// from a valid/ready command port, with per-beat ACK timeout.
module wb_master_standard #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int LENW    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_adr,
   input  logic [LENW-1:0] cmd_len,
   input  logic            wdat_valid,
   output logic            wdat_ready,
   input  logic [DW-1:0]   wdat,
   output logic            rdat_valid,
   output logic [DW-1:0]   rdat,
   output logic            done,
   output logic            err,
   output logic            busy,
   output logic            wb_cyc,
   output logic            wb_stb,
   output logic            wb_we,
   output logic [AW-1:0]   wb_adr,
   output logic [DW-1:0]   wb_dat_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack,
   input  logic            wb_stall
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WDATA, STROBE} state_t;

   state_t          state_q, state_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic [DW-1:0]   rdat_q, rdat_d;
   logic            rdat_valid_q, rdat_valid_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [LENW-1:0] cnt_q, cnt_d;
   logic [TW-1:0]   timer_q, timer_d;

   // Classic cycles never stall; the input exists only for port compatibility.
   logic unused_stall;
   assign unused_stall = wb_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         rdat_q       <= '0;
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         rdat_q       <= rdat_d;
         rdat_valid_q <= rdat_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      stb_d        = stb_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      rdat_d       = rdat_q;
      rdat_valid_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      cnt_d        = cnt_q;
      timer_d      = timer_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               adr_d   = cmd_adr;
               we_d    = cmd_we;
               cnt_d   = cmd_len;
               timer_d = '0;
               cyc_d   = 1'b1;
               if (cmd_we) begin
                  state_d = WDATA;
               end else begin
                  stb_d   = 1'b1;
                  state_d = STROBE;
               end
            end
         end
         WDATA: begin
            if (wdat_valid) begin
               dat_d   = wdat;
               stb_d   = 1'b1;
               state_d = STROBE;
            end
         end
         STROBE: begin
            // ACK is checked before the timer so a late ACK still completes the beat.
            if (wb_ack) begin
               timer_d = '0;
               if (!we_q) begin
                  rdat_d       = wb_dat_i;
                  rdat_valid_d = 1'b1;
               end
               if (cnt_q == '0) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  adr_d = adr_q + 1'b1;
                  if (we_q) begin
                     stb_d   = 1'b0;
                     state_d = WDATA;
                  end
               end
            end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign wdat_ready = (state_q == WDATA);
   assign wb_cyc     = cyc_q;
   assign wb_stb     = stb_q;
   assign wb_we      = we_q;
   assign wb_adr     = adr_q;
   assign wb_dat_o   = dat_q;
   assign rdat       = rdat_q;
   assign rdat_valid = rdat_valid_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_wb_master_standard.sv
// Directed bench for wb_master_standard against a 64k x 16 classic RAM slave model.
module tb_wb_master_standard;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [15:0] cmd_adr;
   logic [7:0]  cmd_len;
   logic        wdat_valid, wdat_ready;
   logic [15:0] wdat;
   logic        rdat_valid;
   logic [15:0] rdat;
   logic        done, err, busy;
   logic        wb_cyc, wb_stb, wb_we;
   logic [15:0] wb_adr, wb_dat_o, wb_dat_i;
   logic        wb_ack, wb_stall;

   wb_master_standard #(.AW(16), .DW(16), .LENW(8), .TIMEOUT(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_len    (cmd_len),
      .wdat_valid (wdat_valid),
      .wdat_ready (wdat_ready),
      .wdat       (wdat),
      .rdat_valid (rdat_valid),
      .rdat       (rdat),
      .done       (done),
      .err        (err),
      .busy       (busy),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_adr     (wb_adr),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack     (wb_ack),
      .wb_stall   (wb_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM slave: registered ACK one cycle after STB, with a backdoor preload port.
   logic [15:0] mem [0:65535];
   logic        ack_en, bk_we;
   logic [15:0] bk_adr, bk_dat;

   always @(posedge clk) begin
      if (bk_we) mem[bk_adr] <= bk_dat;
      wb_ack <= ack_en && wb_cyc && wb_stb && !wb_ack;
      if (wb_cyc && wb_stb && !wb_ack && ack_en) begin
         if (wb_we) mem[wb_adr] <= wb_dat_o;
         else       wb_dat_i    <= mem[wb_adr];
      end
   end

   int n_checks;
   int n_errors;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      bk_adr = a;
      bk_dat = d;
      bk_we  = 1'b1;
      tick();
      bk_we  = 1'b0;
   endtask

   // Per-command observations
   logic [15:0] wdata [8];
   int          done_cyc, ack_cyc, stb_cnt, cyc_cnt, wait_bad, rdv_n;
   logic        err_at_done, cyc_at_done;
   int          rdv_cyc [8];
   logic [15:0] rdv_dat [8];
   logic [15:0] snap;

   task automatic run_cmd(input logic we, input logic [15:0] adr, input logic [7:0] len,
                          input int wdelay, input int limit);
      int  beat;
      logic xfer;
      chk("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      cmd_we    = ~we;
      cmd_adr   = 16'h5555;
      cmd_len   = 8'hFF;
      beat = 0; done_cyc = 0; ack_cyc = 0; stb_cnt = 0; cyc_cnt = 0; wait_bad = 0; rdv_n = 0;
      err_at_done = 1'b0; cyc_at_done = 1'b1; snap = 16'h0;
      for (int c = 1; c <= limit && done_cyc == 0; c++) begin
         wdat_valid = (c > wdelay) && (beat <= int'(len));
         wdat       = (beat < 8) ? wdata[beat] : 16'h0;
         if (wb_stb) stb_cnt++;
         if (wb_cyc) cyc_cnt++;
         if (wb_ack && ack_cyc == 0) ack_cyc = c;
         if (c <= wdelay && (wb_stb || wb_ack)) wait_bad++;
         if (c == wdelay) snap = mem[adr];
         if (rdat_valid && rdv_n < 8) begin
            rdv_cyc[rdv_n] = c;
            rdv_dat[rdv_n] = rdat;
            rdv_n++;
         end
         if (done) begin
            done_cyc    = c;
            err_at_done = err;
            cyc_at_done = wb_cyc;
         end
         xfer = wdat_ready & wdat_valid;
         tick();
         if (xfer) beat++;
      end
      wdat_valid = 1'b0;
   endtask

   int done_seen;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 16'h0; cmd_len = 8'h0;
      wdat_valid = 1'b0; wdat = 16'h0; wb_stall = 1'b0; ack_en = 1'b1;
      bk_we = 1'b0; bk_adr = 16'h0; bk_dat = 16'h0;
      for (int i = 0; i < 8; i++) wdata[i] = 16'h0;
      #3 rst_n = 1'b0;
      tick(); tick();
      chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("rst_stb", {31'd0, wb_stb}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // Single read
      preload(16'h1234, 16'hBEEF);
      run_cmd(1'b0, 16'h1234, 8'd0, 0, 30);
      chk("rd1_done_cyc", done_cyc, 3);
      chk("rd1_err", {31'd0, err_at_done}, 32'd0);
      chk("rd1_rdv_n", rdv_n, 1);
      chk("rd1_rdv_cyc", rdv_cyc[0], 3);
      chk("rd1_rdat", {16'd0, rdv_dat[0]}, 32'hBEEF);
      chk("rd1_cyc_cnt", cyc_cnt, 2);
      chk("rd1_cyc_at_done", {31'd0, cyc_at_done}, 32'd0);

      // Write block across the address wrap
      wdata[0] = 16'h00A0; wdata[1] = 16'h00A1; wdata[2] = 16'h00A2; wdata[3] = 16'h00A3;
      run_cmd(1'b1, 16'hFFFE, 8'd3, 0, 40);
      chk("wrb_done_cyc", done_cyc, 13);
      chk("wrb_err", {31'd0, err_at_done}, 32'd0);
      chk("wrb_stb_cnt", stb_cnt, 8);
      chk("wrb_mem_fffe", {16'd0, mem[16'hFFFE]}, 32'h00A0);
      chk("wrb_mem_ffff", {16'd0, mem[16'hFFFF]}, 32'h00A1);
      chk("wrb_mem_0000", {16'd0, mem[16'h0000]}, 32'h00A2);
      chk("wrb_mem_0001", {16'd0, mem[16'h0001]}, 32'h00A3);

      // Read-back block
      run_cmd(1'b0, 16'hFFFE, 8'd3, 0, 40);
      chk("rdb_done_cyc", done_cyc, 9);
      chk("rdb_stb_cnt", stb_cnt, 8);
      chk("rdb_rdv_n", rdv_n, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rdb_rdv_cyc%0d", i), rdv_cyc[i], 3 + 2 * i);
         chk($sformatf("rdb_rdat%0d", i), {16'd0, rdv_dat[i]}, 32'h00A0 + i);
      end

      // Write with data held off for 5 cycles
      preload(16'h0100, 16'h1111);
      wdata[0] = 16'h5A5A;
      run_cmd(1'b1, 16'h0100, 8'd0, 5, 40);
      chk("wdly_wait_bad", wait_bad, 0);
      chk("wdly_snap", {16'd0, snap}, 32'h1111);
      chk("wdly_cyc_cnt", cyc_cnt, 8);
      chk("wdly_ack_cyc", ack_cyc, 8);
      chk("wdly_done_cyc", done_cyc, 9);
      chk("wdly_mem", {16'd0, mem[16'h0100]}, 32'h5A5A);

      // Timeout against a slave that never acks
      ack_en = 1'b0;
      run_cmd(1'b0, 16'h1234, 8'd2, 0, 30);
      chk("to_stb_cnt", stb_cnt, 8);
      chk("to_done_cyc", done_cyc, 9);
      chk("to_err", {31'd0, err_at_done}, 32'd1);
      chk("to_cyc_at_done", {31'd0, cyc_at_done}, 32'd0);
      chk("to_rdv_n", rdv_n, 0);
      ack_en = 1'b1;
      run_cmd(1'b0, 16'h1234, 8'd0, 0, 30);
      chk("to_next_done_cyc", done_cyc, 3);
      chk("to_next_err", {31'd0, err_at_done}, 32'd0);
      chk("to_next_rdat", {16'd0, rdv_dat[0]}, 32'hBEEF);

      // Asynchronous reset during beat 2 of a 4-beat read
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'hFFFE; cmd_len = 8'd3;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      chk("mid_stb_before", {31'd0, wb_stb}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("mid_stb", {31'd0, wb_stb}, 32'd0);
      chk("mid_we", {31'd0, wb_we}, 32'd0);
      chk("mid_adr", {16'd0, wb_adr}, 32'd0);
      chk("mid_dat_o", {16'd0, wb_dat_o}, 32'd0);
      chk("mid_rdat", {16'd0, rdat}, 32'd0);
      chk("mid_flags", {26'd0, rdat_valid, done, err, busy, wdat_ready, cmd_ready}, 32'd1);
      done_seen = 0;
      tick();
      if (done || err) done_seen++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done || err || busy) done_seen++;
      end
      chk("mid_no_done", done_seen, 0);
      run_cmd(1'b0, 16'h1234, 8'd0, 0, 30);
      chk("post_rst_done_cyc", done_cyc, 3);
      chk("post_rst_rdat", {16'd0, rdv_dat[0]}, 32'hBEEF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_master_standard.md
# wb_master_standard

Wishbone classic standard-cycle initiator. It accepts transfer commands (single or incrementing block, read or write) on a valid/ready command port. It then drives classic standard cycles (CYC/STB held until ACK) toward a Wishbone slave such as the 64k×16 RAM slave. Read data is returned on a response strobe, write data is pulled beat by beat, and a per-beat ACK timeout aborts cycles to unresponsive slaves.

## Interface
- AW, 16, address width (word address)
- DW, 16, data width
- LENW, 8, width of cmd_len (beats minus one)
- TIMEOUT, 255, max cycles STB may wait for ACK per beat; 0 disables the timeout
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both high at a rising edge
- cmd_we  in  1  1 = write block, 0 = read block
- cmd_adr  in  AW  first beat address
- cmd_len  in  LENW  beats − 1 (0 = single cycle)
- wdat_valid / wdat_ready  in / out  1  write-data handshake, one transfer per write beat
- wdat  in  DW  write data
- rdat_valid  out  1  one-cycle pulse per completed read beat
- rdat  out  DW  read data, valid with rdat_valid
- done  out  1  one-cycle pulse at end of command
- err  out  1  pulses with done when the command ended by timeout
- busy  out  1  command in progress
- wb_cyc, wb_stb, wb_we  out  1  Wishbone cycle, strobe, write enable
- wb_adr  out  AW  Wishbone address
- wb_dat_o  out  DW  Wishbone write data
- wb_dat_i  in  DW  Wishbone read data
- wb_ack  in  1  Wishbone acknowledge
- wb_stall  in  1  ignored (classic mode); the bench asserts it stays 0

## Operation
- States: IDLE, WDATA, STROBE. busy = (state != IDLE). cmd_ready = (state == IDLE).
- IDLE: on a cmd handshake, latch wb_adr ← cmd_adr, wb_we ← cmd_we, beat counter ← cmd_len, clear the timer, set wb_cyc = 1.
  - Read commands go to STROBE with wb_stb = 1.
  - Write commands go to WDATA.
- WDATA: wb_cyc = 1, wb_stb = 0, wdat_ready = 1. On wdat_valid, wb_dat_o ← wdat, wb_stb ← 1, go to STROBE.
- STROBE: wb_cyc = wb_stb = 1, all Wishbone outputs held stable until ack.
  - On wb_ack with a read: rdat ← wb_dat_i, rdat_valid pulses the next cycle.
  - On wb_ack with counter = 0: wb_cyc = wb_stb = 0, go to IDLE, done pulses.
  - On wb_ack with counter ≠ 0: counter − 1, wb_adr + 1 (wraps modulo 2^AW, e.g. 0xFFFF → 0x0000), timer cleared.
    - Read stays in STROBE with wb_stb held high.
    - Write goes to WDATA; wb_stb drops for at least one cycle.
- Timeout: the timer counts STROBE cycles without ack. When it reaches TIMEOUT: wb_cyc = wb_stb = 0, go to IDLE, done = err = 1, no rdat_valid; remaining beats are discarded. Timer width is ceil(log2(TIMEOUT+1)).
- Ack in the same cycle the timer reaches TIMEOUT: ack wins; normal completion, no err.
- wb_ack sampled in IDLE or WDATA is ignored.
- cmd_* inputs are sampled only on a handshake; changes afterwards have no effect.

## Timing
- All outputs are registered except cmd_ready, wdat_ready and busy, which are decoded from state.
- Reset values (rst_n low, async):
  - state = IDLE; cmd_ready = 1.
  - wb_cyc = wb_stb = wb_we = 0, wb_adr = 0, wb_dat_o = 0.
  - rdat = 0, rdat_valid = done = err = busy = wdat_ready = 0.
- Reset mid-cycle: wb_cyc/wb_stb drop immediately; no done or err; the command is lost.
- Cycle numbering: the handshake edge ends cycle 0.
- Single read against the RAM slave (ack one cycle after STB): STB high in cycles 1–2, ack in cycle 2, rdat_valid/done in cycle 3, wb_cyc = 0 in cycle 3.
- Read block of N beats: STB continuous in cycles 1..2N; done in cycle 2N+1; rdat_valid in cycles 3, 5, …, 2N+1.
- Write block of N beats, wdat always valid: 3 cycles per beat (WDATA, STROBE, ack); done in cycle 3N+1.
- A new command may be accepted in the done cycle.

## Test plan
- Reset: hold rst_n low mid-simulation → every output equals its reset value in the same cycle; cmd_ready = 1 after release.
- Single read at 0x1234, RAM preloaded 0xBEEF → cycle 3: rdat_valid = 1, rdat = 0xBEEF, done = 1, err = 0; wb_cyc high only in cycles 1–2.
- Write block: adr 0xFFFE, len 3, data 0xA0..0xA3 → RAM[0xFFFE, 0xFFFF, 0x0000, 0x0001] = 0xA0..0xA3, done in cycle 13.
  - Read-back block → 4 rdat pulses with matching data, done in cycle 9.
- Write with wdat_valid low for 5 cycles → wb_cyc = 1, wb_stb = 0, no ack, no RAM write; completes 2 cycles after wdat_valid rises.
- Timeout: TIMEOUT = 8, slave never acks, read len 2 → wb_stb high exactly 8 cycles, then wb_cyc = 0, done = err = 1, no rdat_valid; the next command completes normally.
- Async reset asserted during beat 2 of a 4-beat read → wb_cyc/wb_stb = 0 immediately, no done; the following single read returns correct data.
